// File: rtl/wb_dma_pkg.sv
// -----------------------------------------------------------------------------
// wb_dma_pkg
// Shared definitions for the Wishbone word-copy DMA engine:
//   - state_t                 : copy engine FSM states
//   - SEL_ALL                 : byte-select value for full 32-bit word accesses
//   - DEFAULT_TIMEOUT_CYCLES  : default ack watchdog limit
//   - word_align()            : clears the byte-offset bits of a byte address
//   - is_wait_state()         : true in the states that wait for a slave ack
// -----------------------------------------------------------------------------
package wb_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] SEL_ALL                = 4'hF;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 255;

    // All transfers are whole 32-bit words, so the two byte-offset bits of
    // any supplied address are simply discarded.
    function automatic logic [31:0] word_align(input logic [31:0] adr);
        return adr & ~32'h0000_0003;
    endfunction

    function automatic logic is_wait_state(input state_t st);
        return (st == ST_RD_WAIT) || (st == ST_WR_WAIT);
    endfunction

endpackage : wb_dma_pkg

// File: rtl/wb_ack_watchdog.sv
// -----------------------------------------------------------------------------
// wb_ack_watchdog
// Counts consecutive enabled cycles spent waiting for a Wishbone ack and flags
// expiry on the TIMEOUT_CYCLES-th such cycle.
//
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset, clears the count
//   i_clear    : synchronous clear, has priority over i_enable
//   i_enable   : count this cycle (the master is waiting for an ack)
//   o_expired  : high during the TIMEOUT_CYCLES-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module wb_ack_watchdog
    import wb_dma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // r_count holds the number of enabled cycles already completed, so the
    // cycle in which it equals LAST is the TIMEOUT_CYCLES-th waiting cycle.
    always_ff @(posedge i_clk) begin
        // NOTE: clocked state is written with non-blocking assignments so every
        // flop samples pre-edge values regardless of process ordering.
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_count == LAST);

endmodule : wb_ack_watchdog

// File: rtl/wb_dma_copy.sv
// -----------------------------------------------------------------------------
// wb_dma_copy
// Single-channel Wishbone (pipelined) memory-to-memory word copier. A start
// pulse latches source, destination and word count; the engine then performs
// one read followed by one write per word, holding CYC for the whole transfer.
// A bus error or an ack timeout aborts the transfer and sets a sticky error.
//
// Ports:
//   wb_clk_i, wb_rst_i       : clock and synchronous active-high reset
//   start_i                  : one-cycle request pulse, honoured only in IDLE
//   src_adr_i, dst_adr_i     : byte addresses (word aligned internally)
//   len_i                    : number of 32-bit words to copy
//   busy_o                   : high whenever the engine is not IDLE
//   done_o                   : one-cycle pulse on completion or abort
//   err_o                    : sticky abort flag, cleared by an accepted start
//   wb_cyc_o .. wb_sel_o     : Wishbone master request signals
//   wb_stall_i .. wb_err_i   : Wishbone master response signals
// -----------------------------------------------------------------------------
module wb_dma_copy
    import wb_dma_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,

    input  logic                 start_i,
    input  logic [31:0]          src_adr_i,
    input  logic [31:0]          dst_adr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,

    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [31:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic                 wb_stall_i,
    input  logic                 wb_ack_i,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_err_i
);

    // ---------------------------------------------------------------- state
    state_t               r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_count;
    logic [31:0]          r_buf;
    logic                 r_done;
    logic                 r_err;

    // ------------------------------------------------------ decoded controls
    state_t               w_state_next;
    logic                 w_accept;     // start taken in IDLE
    logic                 w_capture;    // read data returned
    logic                 w_advance;    // write acknowledged, move to next word
    logic                 w_abort;      // bus error or watchdog expiry
    logic                 w_done_next;
    logic                 w_wait;
    logic                 w_expired;
    logic                 w_fault;

    logic                 w_cyc;
    logic                 w_stb;
    logic                 w_we;
    logic [31:0]          w_adr;
    logic [3:0]           w_sel;

    assign w_wait = is_wait_state(r_state);

    // An ack arriving together with an error is still an error, and an ack
    // arriving in the very cycle the watchdog expires wins over the timeout.
    assign w_fault = w_wait && (wb_err_i || (w_expired && !wb_ack_i));

    // The count restarts on every entry to a WAIT state because each WAIT is
    // always preceded by at least one REQ cycle, during which it is cleared.
    wb_ack_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_clear   (!w_wait),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    // --------------------------------------------- next state and bus drive
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_abort      = 1'b0;
        w_done_next  = 1'b0;
        w_cyc        = 1'b0;
        w_stb        = 1'b0;
        w_we         = 1'b0;
        w_adr        = '0;
        w_sel        = '0;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    if (len_i != '0) begin
                        w_state_next = ST_RD_REQ;
                    end else begin
                        // Zero-length request completes without touching the bus.
                        w_done_next = 1'b1;
                    end
                end
            end

            ST_RD_REQ: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                w_sel = SEL_ALL;
                w_adr = r_src;
                if (!wb_stall_i) begin
                    w_state_next = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                w_cyc = 1'b1;
                w_adr = r_src;
                if (w_fault) begin
                    w_abort      = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (wb_ack_i) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_WR_REQ;
                end
            end

            ST_WR_REQ: begin
                w_cyc = 1'b1;
                w_stb = 1'b1;
                w_we  = 1'b1;
                w_sel = SEL_ALL;
                w_adr = r_dst;
                if (!wb_stall_i) begin
                    w_state_next = ST_WR_WAIT;
                end
            end

            ST_WR_WAIT: begin
                w_cyc = 1'b1;
                w_adr = r_dst;
                if (w_fault) begin
                    w_abort      = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (wb_ack_i) begin
                    w_advance = 1'b1;
                    if (r_count == LEN_WIDTH'(1)) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_RD_REQ;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------ state registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            // NOTE: the data buffer is reset along with the control state
            // because it drives wb_dat_o directly and must read as zero after
            // reset; it is a single register, not a memory array.
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_buf   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;

            if (w_accept) begin
                r_err   <= 1'b0;
                r_src   <= word_align(src_adr_i);
                r_dst   <= word_align(dst_adr_i);
                r_count <= len_i;
            end

            if (w_abort) begin
                r_err <= 1'b1;
            end

            if (w_capture) begin
                r_buf <= wb_dat_i;
            end

            // Addresses wrap naturally at 2^32 through the 32-bit add.
            if (w_advance) begin
                r_src   <= r_src + 32'd4;
                r_dst   <= r_dst + 32'd4;
                r_count <= r_count - LEN_WIDTH'(1);
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign busy_o   = (r_state != ST_IDLE);
    assign done_o   = r_done;
    assign err_o    = r_err;

    assign wb_cyc_o = w_cyc;
    assign wb_stb_o = w_stb;
    assign wb_we_o  = w_we;
    assign wb_adr_o = w_adr;
    assign wb_sel_o = w_sel;
    assign wb_dat_o = r_buf;

endmodule : wb_dma_copy

// File: tb/tb_wb_dma_copy.sv
// -----------------------------------------------------------------------------
// tb_wb_dma_copy
// Self-checking bench for wb_dma_copy. A table of transfer records (addresses,
// length, slave behaviour, expected timing and status) is applied in a loop;
// a hand-written sequence covers reset in the middle of a transfer.
// The slave is a zero-wait memory that acks one cycle after accepting a
// request, with optional stalls, error injection or no ack at all.
// -----------------------------------------------------------------------------
module tb_wb_dma_copy;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [LW-1:0] len;
    logic          busy, done, err;
    logic          cyc, stb, we;
    logic [31:0]   adr, dat_o;
    logic [3:0]    sel;
    logic          stall;
    logic          ack   = 1'b0;
    logic          serr  = 1'b0;
    logic [31:0]   rdata = '0;

    always #5 clk = ~clk;

    wb_dma_copy #(
        .TIMEOUT_CYCLES (8),
        .LEN_WIDTH      (LW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .src_adr_i  (src),
        .dst_adr_i  (dst),
        .len_i      (len),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .wb_cyc_o   (cyc),
        .wb_stb_o   (stb),
        .wb_we_o    (we),
        .wb_adr_o   (adr),
        .wb_dat_o   (dat_o),
        .wb_sel_o   (sel),
        .wb_stall_i (stall),
        .wb_ack_i   (ack),
        .wb_dat_i   (rdata),
        .wb_err_i   (serr)
    );

    // ------------------------------------------------------------ scoring
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // --------------------------------------------------------- slave model
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [$];
    int          rd_seen, wr_seen, stall_used;
    int          stall_idx = -1, stall_len = 0, err_wr = -1;
    bit          never_ack = 1'b0;
    bit          inj_err   = 1'b0;

    // Odd multiplier makes the pattern unique per address.
    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pattern(a);
    endfunction

    // Runs at each negedge: decides stall/error for the current request and
    // performs the memory write of a request that will be accepted this edge.
    task automatic slave_prep();
        stall = (cyc && stb && !we && (rd_seen == stall_idx) && (stall_used < stall_len));
        if (stall) stall_used++;
        inj_err = 1'b0;
        if (cyc && stb && !stall) begin
            if (!we) begin
                rd_log.push_back(adr);
                rd_seen++;
            end else begin
                if (wr_seen == err_wr) inj_err = 1'b1;
                else if (!never_ack) mem[adr] = dat_o;
                wr_seen++;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            ack  <= 1'b0;
            serr <= 1'b0;
        end else begin
            ack  <= 1'b0;
            serr <= 1'b0;
            if (cyc && stb && !stall) begin
                rdata <= mem_rd(adr);
                if (inj_err) begin
                    ack  <= 1'b1;   // ack together with err must still abort
                    serr <= 1'b1;
                end else if (!never_ack) begin
                    ack <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------- vector table
    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        int          stall_idx;   // read index to stall (-1 none)
        int          stall_len;
        int          err_wr;      // write index answered with err (-1 none)
        bit          never_ack;
        int          busy_start;  // cycle of a stray start pulse (0 none)
        int          exp_done;    // cycle of done_o, start edge = cycle 0
        int          exp_cyc;     // cycles with wb_cyc_o high
        int          exp_hold;    // cycles of stb with adr = second read address
        bit          exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int id, input vec_t v);
        logic [31:0] s_al, d_al;
        int          n, done_at, cyc_cnt, hold;
        bit          cyc_ended, gap;
        s_al = v.src & ~32'h3;
        d_al = v.dst & ~32'h3;
        rd_log.delete();
        rd_seen    = 0;
        wr_seen    = 0;
        stall_used = 0;
        stall_idx  = v.stall_idx;
        stall_len  = v.stall_len;
        err_wr     = v.err_wr;
        never_ack  = v.never_ack;
        n = 0; done_at = -1; cyc_cnt = 0; hold = 0; cyc_ended = 0; gap = 0;

        src = v.src; dst = v.dst; len = LW'(v.len); start = 1'b1;
        while (done_at < 0 && n < 100) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == v.busy_start) begin
                start = 1'b1; src = 32'h0000_0900; dst = 32'h0000_0C00; len = LW'(5);
            end
            slave_prep();
            if (n == 1) begin
                check($sformatf("v%0d err_cleared_on_start", id), 32'(err), 32'd0);
                if (v.len != 0) begin
                    check($sformatf("v%0d busy_c1", id), 32'(busy), 32'd1);
                    check($sformatf("v%0d stb_c1", id), 32'(stb), 32'd1);
                    check($sformatf("v%0d we_c1", id), 32'(we), 32'd0);
                    check($sformatf("v%0d sel_c1", id), 32'(sel), 32'hF);
                    check($sformatf("v%0d adr_c1", id), adr, s_al);
                end
            end
            if (cyc) begin
                cyc_cnt++;
                if (cyc_ended) gap = 1'b1;
            end else if (cyc_cnt > 0) begin
                cyc_ended = 1'b1;
            end
            if (stb && !we && (adr == s_al + 32'd4)) hold++;
            if (done) done_at = n;
        end

        if (done_at < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL v%0d done_wait: no done_o within %0d cycles", id, n);
        end else begin
            check($sformatf("v%0d done_cycle", id), 32'(done_at), 32'(v.exp_done));
            check($sformatf("v%0d err_at_done", id), 32'(err), 32'(v.exp_err));
            check($sformatf("v%0d cyc_at_done", id), 32'(cyc), 32'd0);
            check($sformatf("v%0d busy_at_done", id), 32'(busy), 32'd0);
            check($sformatf("v%0d cyc_cycles", id), 32'(cyc_cnt), 32'(v.exp_cyc));
            check($sformatf("v%0d cyc_gap", id), 32'(gap), 32'd0);
            if (!v.exp_err) begin
                check($sformatf("v%0d read_count", id), 32'(rd_log.size()), 32'(v.len));
                for (int k = 0; k < v.len && k < rd_log.size(); k++) begin
                    check($sformatf("v%0d rd_adr%0d", id, k), rd_log[k], s_al + 32'(4 * k));
                    check($sformatf("v%0d word%0d", id, k), mem_rd(d_al + 32'(4 * k)),
                          pattern(s_al + 32'(4 * k)));
                end
                if (v.len >= 2) begin
                    check($sformatf("v%0d rd1_hold", id), 32'(hold), 32'(v.exp_hold));
                end
            end else begin
                check($sformatf("v%0d dst_unchanged", id), dut.r_dst, d_al);
            end
        end

        @(negedge clk);
        slave_prep();
        check($sformatf("v%0d done_one_cycle", id), 32'(done), 32'd0);
        check($sformatf("v%0d err_sticky", id), 32'(err), 32'(v.exp_err));
        stall = 1'b0;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int done_seen;
        vec_t fresh;

        //            src            dst           len sidx slen ewr nack bsy done cyc hold err
        vecs[0] = '{32'h0000_0100, 32'h0000_0200, 3, -1, 0, -1, 1'b0, 0, 13, 12, 1, 1'b0};
        vecs[1] = '{32'h0000_0800, 32'h0000_0900, 3,  1, 3, -1, 1'b0, 0, 16, 15, 4, 1'b0};
        vecs[2] = '{32'h0000_0100, 32'h0000_0A00, 3, -1, 0,  0, 1'b0, 0,  5,  4, 0, 1'b1};
        vecs[3] = '{32'h0000_1000, 32'h0000_2000, 1, -1, 0, -1, 1'b0, 0,  5,  4, 0, 1'b0};
        vecs[4] = '{32'h0000_1234, 32'h0000_5678, 0, -1, 0, -1, 1'b0, 0,  1,  0, 0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0300, 2, -1, 0, -1, 1'b0, 0,  9,  8, 1, 1'b0};
        vecs[6] = '{32'h0000_0400, 32'h0000_0500, 2, -1, 0, -1, 1'b0, 3,  9,  8, 1, 1'b0};
        vecs[7] = '{32'h0000_0040, 32'h0000_0050, 1, -1, 0, -1, 1'b1, 0, 10,  9, 0, 1'b1};
        vecs[8] = '{32'h0000_0703, 32'h0000_0B02, 2, -1, 0, -1, 1'b0, 0,  9,  8, 1, 1'b0};

        rst = 1'b1; start = 1'b0; stall = 1'b0;
        src = '0; dst = '0; len = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err",  32'(err),  32'd0);
        check("reset cyc",  32'(cyc),  32'd0);
        check("reset stb",  32'(stb),  32'd0);
        check("reset adr",  adr,       32'd0);
        check("reset sel",  32'(sel),  32'd0);
        check("reset dat",  dat_o,     32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset during the WR_WAIT of the second word.
        rd_log.delete();
        rd_seen = 0; wr_seen = 0; stall_used = 0;
        stall_idx = -1; err_wr = -1; never_ack = 1'b0;
        src = 32'h0000_0100; dst = 32'h0000_0600; len = LW'(3); start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            start = 1'b0;
            slave_prep();
        end
        check("rst_seq in_wr_wait cyc", 32'(cyc), 32'd1);
        check("rst_seq in_wr_wait stb", 32'(stb), 32'd0);
        check("rst_seq in_wr_wait wr_count", 32'(wr_seen), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        slave_prep();
        check("rst_seq cyc",  32'(cyc),  32'd0);
        check("rst_seq busy", 32'(busy), 32'd0);
        check("rst_seq done", 32'(done), 32'd0);
        check("rst_seq err",  32'(err),  32'd0);
        check("rst_seq dat",  dat_o,     32'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            slave_prep();
            if (done || cyc) done_seen++;
        end
        check("rst_seq no_resume_no_done", 32'(done_seen), 32'd0);

        fresh = '{32'h0000_3000, 32'h0000_4000, 2, -1, 0, -1, 1'b0, 0, 9, 8, 1, 1'b0};
        run_vec(9, fresh);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: bench did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule : tb_wb_dma_copy

// File: doc/wb_dma_copy.md
WB_DMA_COPY -- requirements
Module: wb_dma_copy

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for an ack before abort.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, giving the width of the word-count field.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have wb_clk_i (input, 1): clock; all logic on its rising edge.
REQ-005 SHALL have wb_rst_i (input, 1): synchronous active-high reset.
REQ-006 SHALL have start_i (input, 1): one-cycle transfer request pulse.
REQ-007 SHALL have src_adr_i, dst_adr_i (input, 32): byte addresses, sampled on start_i.
REQ-008 SHALL have len_i (input, LEN_WIDTH): word count, sampled on start_i.
REQ-009 SHALL have busy_o (output, 1), done_o (output, 1, pulse) and err_o (output, 1, sticky).
REQ-010 SHALL have Wishbone pipelined master outputs wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_adr_o (32), wb_dat_o (32), wb_sel_o (4).
REQ-011 SHALL have Wishbone master inputs wb_stall_i (1), wb_ack_i (1), wb_dat_i (32), wb_err_i (1).

Function
REQ-012 SHALL implement states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-013 In IDLE, start_i=1 with len_i!=0 SHALL do all of the following:
- latch src/dst with bits [1:0] forced to 00;
- latch len;
- enter RD_REQ next cycle.
REQ-014 In IDLE, start_i=1 with len_i=0 SHALL pulse done_o next cycle with no bus activity.
REQ-015 start_i outside IDLE SHALL be ignored.
REQ-016 RD_REQ SHALL drive cyc=1, stb=1, we=0, sel=4'hF, adr=current src.
REQ-017 RD_REQ SHALL hold stb, adr and we stable while wb_stall_i=1, and enter RD_WAIT on the first cycle with wb_stall_i=0.
REQ-018 RD_WAIT SHALL drive cyc=1, stb=0.
REQ-019 On wb_ack_i in RD_WAIT, the block SHALL capture wb_dat_i into the data buffer and enter WR_REQ.
REQ-020 WR_REQ SHALL drive cyc=1, stb=1, we=1, sel=4'hF, adr=current dst, dat=buffer, with the same stall rule as RD_REQ, then enter WR_WAIT.
REQ-021 On wb_ack_i in WR_WAIT, the block SHALL do all of the following:
- add 4 to src and to dst, modulo 2^32 (0xFFFFFFFC wraps to 0);
- decrement the remaining count;
- go to RD_REQ if the count is nonzero, else go to IDLE and pulse done_o.
REQ-022 wb_ack_i during RD_REQ/WR_REQ or in IDLE SHALL be ignored.
REQ-023 wb_cyc_o SHALL stay high continuously from the first RD_REQ through the final WR_WAIT ack.
REQ-024 Throughput SHALL be 4 cycles/word against a zero-stall, next-cycle-ack slave.
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 done_o SHALL be high exactly one cycle, coincident with the first IDLE cycle after completion or abort.
REQ-027 Abort SHALL occur on either of the following:
- wb_err_i=1 in a WAIT state;
- watchdog expiry: TIMEOUT_CYCLES consecutive WAIT-state cycles without ack, counter cleared on each WAIT entry.
REQ-028 On abort, the block SHALL go to IDLE, drop cyc/stb the next cycle, set err_o=1 and pulse done_o.
REQ-029 err_o SHALL clear only on an accepted start_i or on reset.
REQ-030 wb_ack_i and wb_err_i in the same cycle SHALL be treated as an error.

Reset
REQ-031 wb_rst_i SHALL, at the clock edge, force IDLE and clear the following to 0 from the next cycle, including mid-transfer:
- cyc, stb, we, busy, done, err;
- adr, dat, sel;
- count, watchdog.
REQ-032 A transfer interrupted by reset SHALL NOT resume, and SHALL NOT pulse done_o.

Structure
REQ-033 Package wb_dma_pkg SHALL hold the state enum, the SEL_ALL=4'hF constant and the default TIMEOUT_CYCLES.
REQ-034 The watchdog SHALL be a sub-module wb_ack_watchdog, with clear/enable inputs and an expired output.
REQ-035 The remaining FSM, address/count registers and data buffer SHALL reside in wb_dma_copy.

Verification
REQ-036 Copy: src=0x100, dst=0x200, len=3, zero-stall slave acking next cycle -> the following:
- words copied in order;
- done_o at cycle 13 after start;
- err_o=0;
- cyc continuously high for 12 cycles.
REQ-037 Stall: wb_stall_i=1 for 3 cycles on the second read -> adr=0x104 and stb held steady for 4 cycles; data correct.
REQ-038 Error: wb_err_i on the first write ack -> the following:
- cyc=0 next cycle;
- done_o pulse, err_o=1;
- dst unchanged;
- next start clears err_o.
REQ-039 Timeout: TIMEOUT_CYCLES=8, slave never acks -> abort exactly 8 WAIT cycles after entry; err_o=1.
REQ-040 Edge cases, each as follows:
- len=0 -> done_o next cycle, no stb;
- start during busy -> ignored;
- src=0xFFFFFFFC, len=2 -> second read at 0x0.
REQ-041 Reset asserted in WR_WAIT of word 2 -> cyc=0, busy=0 next cycle; no done_o; fresh start works.
